// File: rtl/key_debouncer.sv
// Per-key debouncer sampled on rising edges of clk_divd; optional auto-repeat under KEY_REPEAT_EN.
// Latency: press/release pulses one clk after the STABLE_CNT-th agreeing strobe; no backpressure (pulses are not held).
module key_debouncer #(
  parameter int NKEYS       = 4,
  parameter int STABLE_CNT  = 4,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_divd,
  input  logic [NKEYS-1:0] key_in,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic             any_pressed
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  logic [NKEYS-1:0] key_s1, key_s2;
  logic             divd_s1, divd_s2, divd_d, strobe;

  state_t           state_q [NKEYS];
  state_t           state_d [NKEYS];
  logic [CW-1:0]    cnt_q   [NKEYS];
  logic [CW-1:0]    cnt_d   [NKEYS];
  logic [NKEYS-1:0] level_d, press_d, release_d;

`ifdef KEY_REPEAT_EN
  // rpt_arm: first repeat already fired, so the period is now REPEAT_RATE
  logic [15:0]      rpt_cnt_q [NKEYS];
  logic [15:0]      rpt_cnt_d [NKEYS];
  logic [NKEYS-1:0] rpt_arm_q, rpt_arm_d;
`else
  logic [31:0] unused_rpt;
  assign unused_rpt = REPEAT_DLY ^ REPEAT_RATE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1  <= '0;
      key_s2  <= '0;
      divd_s1 <= 1'b0;
      divd_s2 <= 1'b0;
      divd_d  <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      key_s1  <= key_in;
      key_s2  <= key_s1;
      divd_s1 <= clk_divd;
      divd_s2 <= divd_s1;
      divd_d  <= divd_s2;
      strobe  <= divd_s2 & ~divd_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NKEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
`ifdef KEY_REPEAT_EN
      rpt_cnt_d[k] = rpt_cnt_q[k];
`endif
    end
`ifdef KEY_REPEAT_EN
    rpt_arm_d = rpt_arm_q;
`endif
    level_d   = key_level;
    press_d   = '0;
    release_d = '0;

    if (strobe) begin
      for (int k = 0; k < NKEYS; k++) begin
        case (state_q[k])
          IDLE: begin
            if (key_s2[k]) begin
              state_d[k] = PRESS_CHK;
              cnt_d[k]   = CW'(1);
            end
          end
          PRESS_CHK: begin
            if (!key_s2[k]) begin
              state_d[k] = IDLE;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] + CW'(1) == CW'(STABLE_CNT)) begin
              state_d[k] = HELD;
              cnt_d[k]   = '0;
              level_d[k] = 1'b1;
              press_d[k] = 1'b1;
`ifdef KEY_REPEAT_EN
              rpt_cnt_d[k] = '0;
              rpt_arm_d[k] = 1'b0;
`endif
            end else begin
              cnt_d[k] = cnt_q[k] + CW'(1);
            end
          end
          HELD: begin
            if (!key_s2[k]) begin
              state_d[k] = REL_CHK;
              cnt_d[k]   = CW'(1);
            end else begin
`ifdef KEY_REPEAT_EN
              if (rpt_cnt_q[k] + 16'd1 ==
                  (rpt_arm_q[k] ? 16'(REPEAT_RATE) : 16'(REPEAT_DLY))) begin
                press_d[k]   = 1'b1;
                rpt_cnt_d[k] = '0;
                rpt_arm_d[k] = 1'b1;
              end else begin
                rpt_cnt_d[k] = rpt_cnt_q[k] + 16'd1;
              end
`endif
            end
          end
          REL_CHK: begin
            // a high sample returns to HELD; the repeat counter resumes where it paused
            if (key_s2[k]) begin
              state_d[k] = HELD;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] + CW'(1) == CW'(STABLE_CNT)) begin
              state_d[k]   = IDLE;
              cnt_d[k]     = '0;
              level_d[k]   = 1'b0;
              release_d[k] = 1'b1;
            end else begin
              cnt_d[k] = cnt_q[k] + CW'(1);
            end
          end
          default: begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
`ifdef KEY_REPEAT_EN
        rpt_cnt_q[k] <= '0;
`endif
      end
`ifdef KEY_REPEAT_EN
      rpt_arm_q <= '0;
`endif
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_pressed <= 1'b0;
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
`ifdef KEY_REPEAT_EN
        rpt_cnt_q[k] <= rpt_cnt_d[k];
`endif
      end
`ifdef KEY_REPEAT_EN
      rpt_arm_q <= rpt_arm_d;
`endif
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      any_pressed <= |level_d;
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboarded bench for key_debouncer: one strobe per 20-clk period, expected pulses queued per period.
module tb_key_debouncer;

  localparam int STABLE = 4;
  localparam int DLY    = 8;
  localparam int RATE   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_divd;
  logic [3:0] key_in;
  logic [3:0] key_level, key_press, key_release;
  logic       any_pressed;

  key_debouncer #(
    .NKEYS(4), .STABLE_CNT(STABLE), .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_divd(clk_divd), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         per;
    logic [3:0] press;
    logic [3:0] rel;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   per   = 0;

  // reference: a key flips its accepted level after STABLE samples in a row that disagree with it
  logic [3:0] m_lvl;
  int         m_diff [4];
  int         m_run  [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (period %0d)", tag, obs, exp, per);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0;
    for (int i = 0; i < 4; i++) begin
      m_diff[i] = 0;
      m_run[i]  = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] k, output logic [3:0] pr, output logic [3:0] rl);
    pr = '0;
    rl = '0;
    for (int i = 0; i < 4; i++) begin
      if (k[i] != m_lvl[i]) begin
        m_diff[i]++;
        if (m_diff[i] == STABLE) begin
          m_lvl[i]  = k[i];
          m_diff[i] = 0;
          m_run[i]  = 0;
          if (k[i]) pr[i] = 1'b1;
          else      rl[i] = 1'b1;
        end
      end else begin
`ifdef KEY_REPEAT_EN
        if (m_lvl[i] && m_diff[i] == 0) begin
          m_run[i]++;
          if (m_run[i] == DLY || (m_run[i] > DLY && (m_run[i] - DLY) % RATE == 0))
            pr[i] = 1'b1;
        end
`endif
        m_diff[i] = 0;
      end
    end
  endtask

  // one strobe period: keys and a low divider for 10 clk, then divider high for 10 clk
  task automatic period(input logic [3:0] k);
    logic [3:0] pr, rl;
    exp_t e;
    @(posedge clk);
    #1;
    per++;
    key_in   = k;
    clk_divd = 1'b0;
    if (rst_n) begin
      model_step(k, pr, rl);
      if (|{pr, rl}) begin
        e.per = per; e.press = pr; e.rel = rl;
        sb.push_back(e);
      end
    end
    repeat (10) @(posedge clk);
    #1 clk_divd = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("level", 32'(key_level), 32'(m_lvl));
    check("any_pressed", 32'(any_pressed), 32'(|m_lvl));
  endtask

  task automatic run(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) period(k);
  endtask

  logic last_pulse = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (last_pulse) check("pulse_width", 32'({key_press, key_release}), 32'd0);
    last_pulse <= |{key_press, key_release};
    if (|{key_press, key_release}) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({key_press, key_release}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("press", 32'(key_press), 32'(e.press));
        check("release", 32'(key_release), 32'(e.rel));
        check("pulse_period", 32'(per), 32'(e.per));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    key_in   = '0;
    clk_divd = 1'b0;
    model_reset();

    // reset held with divider toggling and all keys down
    run(4'hF, 3);
    @(posedge clk);
    #1 clk_divd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run(4'hF, 4);

    // reset while held: level clears at once, no release pulse
    @(posedge clk);
    #1 clk_divd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_level", 32'(key_level), 32'd0);
    check("rst_any", 32'(any_pressed), 32'd0);
    check("rst_sb_empty", 32'(sb.size()), 32'd0);
    model_reset();
    key_in = '0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    run(4'h0, 3);

    // clean press then release on key 0
    run(4'h1, 10);
    run(4'h0, 4);

    // bounce on key 1, then a clean press
    period(4'h2); period(4'h2); period(4'h0);
    period(4'h2); period(4'h2); period(4'h2); period(4'h0);
    run(4'h2, 4);
    run(4'h0, 4);

    // release glitch on key 2, then a real release
    run(4'h4, 4);
    run(4'h0, 2);
    run(4'h4, 1);
    run(4'h0, 4);

    // simultaneous keys, then key 2 bouncing while key 0 holds
    run(4'h5, 4);
    period(4'h1); period(4'h5); period(4'h1); period(4'h1); period(4'h5);
    run(4'h0, 4);

    // long hold on key 3 (auto-repeat when enabled)
    run(4'h8, 20);
    run(4'h0, 4);

    repeat (30) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
